// File: rtl/mpmc11_cmd_fsm.sv
// mpmc11 command sequencer: walks one port request strip by strip onto the DDR UI.
// Optional stall watchdog is compiled in with MPMC11_CMD_TIMEOUT_EN.
package mpmc11_pkg;
  typedef enum logic [2:0] {
    IDLE,
    PRESET,
    WRITE_DATA0,
    WRITE_DATA1,
    READ_DATA0,
    READ_DATA1,
    WAIT_NACK
  } mpmc11_state_t;
endpackage

module mpmc11_cmd_fsm
  import mpmc11_pkg::*;
#(
  parameter int STRIP_W   = 6,
  parameter int TO_CYCLES = 1023
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               calib_done,
  input  logic               req,
  input  logic               req_we,
  input  logic [STRIP_W-1:0] req_strips,
  input  logic               app_rdy,
  input  logic               app_wdf_rdy,
  input  logic               app_rd_data_valid,
  output logic               app_en,
  output logic [2:0]         app_cmd,
  output logic               app_wdf_wren,
  output logic               app_wdf_end,
  output mpmc11_state_t      state,
  output logic [STRIP_W-1:0] cmd_strip,
  output logic [STRIP_W-1:0] resp_strip,
  output logic               ack,
  output logic               timeout
);

  mpmc11_state_t state_q, state_d;
  logic we_q, we_d;
  logic [STRIP_W-1:0] n_q, n_d;
  logic [STRIP_W-1:0] cmd_q, cmd_d;
  logic [STRIP_W-1:0] resp_q, resp_d;
  logic rd_st;

  assign rd_st = (state_q == READ_DATA0) || (state_q == READ_DATA1);

  assign app_en       = (state_q == WRITE_DATA1) || (state_q == READ_DATA0);
  assign app_cmd      = (state_q == READ_DATA0) ? 3'b001 : 3'b000;
  assign app_wdf_wren = (state_q == WRITE_DATA0);
  assign app_wdf_end  = app_wdf_wren;
  assign state        = state_q;
  assign cmd_strip    = cmd_q;
  assign resp_strip   = resp_q;
  assign ack          = (state_q == WAIT_NACK);

`ifdef MPMC11_CMD_TIMEOUT_EN
  localparam int TW = $clog2(TO_CYCLES + 1);
  logic [TW-1:0] wd_q, wd_d;
  logic to_q, to_d;
  logic hs;

  assign hs = (app_en && app_rdy) || (app_wdf_wren && app_wdf_rdy)
            || app_rd_data_valid;
  assign timeout = to_q;
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    n_d     = n_q;
    cmd_d   = cmd_q;
    resp_d  = resp_q;
`ifdef MPMC11_CMD_TIMEOUT_EN
    wd_d    = wd_q + TW'(1);
    to_d    = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (calib_done && req) begin
          we_d    = req_we;
          n_d     = req_strips;
          state_d = PRESET;
        end
      end
      PRESET: begin
        cmd_d   = '0;
        resp_d  = '0;
        state_d = we_q ? WRITE_DATA0 : READ_DATA0;
      end
      WRITE_DATA0: if (app_wdf_rdy) state_d = WRITE_DATA1;
      WRITE_DATA1: begin
        if (app_rdy) begin
          if (cmd_q == n_q) begin
            state_d = WAIT_NACK;
          end else begin
            cmd_d   = cmd_q + STRIP_W'(1);
            state_d = WRITE_DATA0;
          end
        end
      end
      READ_DATA0: begin
        if (app_rdy) begin
          if (cmd_q == n_q) state_d = READ_DATA1;
          else cmd_d = cmd_q + STRIP_W'(1);
        end
      end
      READ_DATA1: ;
      WAIT_NACK: if (!req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Final read strip wins over any command progress in the same cycle.
    if (rd_st && app_rd_data_valid) begin
      resp_d = resp_q + STRIP_W'(1);
      if (resp_q == n_q) state_d = WAIT_NACK;
    end
`ifdef MPMC11_CMD_TIMEOUT_EN
    if (state_q == IDLE || state_q == WAIT_NACK || hs) begin
      wd_d = '0;
    end else if (wd_q == TW'(TO_CYCLES - 1)) begin
      wd_d    = '0;
      to_d    = 1'b1;
      state_d = IDLE;
    end
`endif
    if (state_d == IDLE) begin
      cmd_d  = '0;
      resp_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      n_q     <= '0;
      cmd_q   <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      n_q     <= n_d;
      cmd_q   <= cmd_d;
      resp_q  <= resp_d;
    end
  end

`ifdef MPMC11_CMD_TIMEOUT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wd_q <= '0;
      to_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      to_q <= to_d;
    end
  end
`endif

endmodule

// File: tb/tb_mpmc11_cmd_fsm.sv
// Bench for mpmc11_cmd_fsm: transaction-level reference model, random UI
// readiness and read latency, plus directed latency and corner scenarios.
`timescale 1ns/1ps
module tb_mpmc11_cmd_fsm;
  import mpmc11_pkg::*;

  localparam int SW = 6;
  localparam int TO = 16;
  localparam int MASK = (1 << SW) - 1;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic calib_done = 1'b0;
  logic req = 1'b0;
  logic req_we = 1'b0;
  logic [SW-1:0] req_strips = '0;
  logic app_rdy = 1'b1;
  logic app_wdf_rdy = 1'b1;
  logic rsp_valid = 1'b0;
  logic spur = 1'b0;
  logic app_rd_data_valid;
  logic app_en, app_wdf_wren, app_wdf_end, ack, timeout;
  logic [2:0] app_cmd;
  logic [SW-1:0] cmd_strip, resp_strip;
  mpmc11_state_t state;

  assign app_rd_data_valid = rsp_valid | spur;

  mpmc11_cmd_fsm #(.STRIP_W(SW), .TO_CYCLES(TO)) dut (
    .clk(clk), .rstn(rstn), .calib_done(calib_done),
    .req(req), .req_we(req_we), .req_strips(req_strips),
    .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data_valid(app_rd_data_valid),
    .app_en(app_en), .app_cmd(app_cmd),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .state(state), .cmd_strip(cmd_strip), .resp_strip(resp_strip),
    .ack(ack), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int rmode = 0;
  int wmode = 0;
  int rd_stall = 0;
  int rsp_lat = 2;
  int rq[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: tracks the transaction by issued/returned strip counts.
  mpmc11_state_t m_st = IDLE;
  int m_cmd = 0, m_resp = 0, m_n = 0, m_wd = 0;
  bit m_we = 0, m_to = 0;

  always @(posedge clk) begin
    bit i_cal, i_req, i_we, i_rdy, i_wrdy, i_vld, e_en, e_wren, hs;
    int i_n, t;
    mpmc11_state_t nx;
    i_cal = calib_done; i_req = req; i_we = req_we; i_n = int'(req_strips);
    i_rdy = app_rdy; i_wrdy = app_wdf_rdy; i_vld = app_rd_data_valid;
    if (!rstn) begin
      rq.delete();
    end else if (app_en && app_rdy && app_cmd == 3'b001) begin
      t = cyc + rsp_lat;
      if (rq.size() > 0 && t <= rq[$]) t = rq[$] + 1;
      rq.push_back(t);
    end
    cyc++;
    if (!rstn) begin
      m_st = IDLE; m_cmd = 0; m_resp = 0; m_n = 0; m_we = 0;
      m_wd = 0; m_to = 0;
    end else begin
      e_en = (m_st == WRITE_DATA1) || (m_st == READ_DATA0);
      e_wren = (m_st == WRITE_DATA0);
      nx = m_st;
      m_to = 0;
      case (m_st)
        IDLE: if (i_cal && i_req) begin
          m_we = i_we; m_n = i_n; nx = PRESET;
        end
        PRESET: begin
          m_cmd = 0; m_resp = 0;
          nx = m_we ? WRITE_DATA0 : READ_DATA0;
        end
        WRITE_DATA0: if (i_wrdy) nx = WRITE_DATA1;
        WRITE_DATA1: if (i_rdy) begin
          if (m_cmd == m_n) nx = WAIT_NACK;
          else begin m_cmd++; nx = WRITE_DATA0; end
        end
        READ_DATA0: if (i_rdy) begin
          if (m_cmd == m_n) nx = READ_DATA1;
          else m_cmd++;
        end
        WAIT_NACK: if (!i_req) nx = IDLE;
        default: ;
      endcase
      if ((m_st == READ_DATA0 || m_st == READ_DATA1) && i_vld) begin
        if (m_resp == m_n) nx = WAIT_NACK;
        m_resp = (m_resp + 1) & MASK;
      end
`ifdef MPMC11_CMD_TIMEOUT_EN
      hs = (e_en && i_rdy) || (e_wren && i_wrdy) || i_vld;
      if (m_st == IDLE || m_st == WAIT_NACK || hs) m_wd = 0;
      else begin
        m_wd++;
        if (m_wd == TO) begin m_wd = 0; m_to = 1; nx = IDLE; end
      end
`else
      hs = e_en && e_wren;
`endif
      if (nx == IDLE) begin m_cmd = 0; m_resp = 0; end
      m_st = nx;
    end
    #1;
    chk("state", state, m_st);
    chk("app_en", app_en, (m_st == WRITE_DATA1) || (m_st == READ_DATA0));
    chk("app_cmd", app_cmd, (m_st == READ_DATA0) ? 3'b001 : 3'b000);
    chk("app_wdf_wren", app_wdf_wren, m_st == WRITE_DATA0);
    chk("app_wdf_end", app_wdf_end, m_st == WRITE_DATA0);
    chk("cmd_strip", cmd_strip, m_cmd);
    chk("resp_strip", resp_strip, m_resp);
    chk("ack", ack, m_st == WAIT_NACK);
    chk("timeout", timeout, m_to);
  end

  // UI readiness and read-data responder.
  always @(negedge clk) begin
    case (rmode)
      0: app_rdy = 1'b1;
      1: app_rdy = ($urandom % 4) != 0;
      default: app_rdy = 1'b0;
    endcase
    if (rd_stall > 0 && state == READ_DATA0 && cmd_strip == 1) begin
      app_rdy = 1'b0;
      rd_stall--;
    end
    case (wmode)
      0: app_wdf_rdy = 1'b1;
      1: app_wdf_rdy = ($urandom % 4) != 0;
      default: app_wdf_rdy = 1'b0;
    endcase
    rsp_valid = 1'b0;
    if (rq.size() > 0 && rq[0] <= cyc) begin
      void'(rq.pop_front());
      rsp_valid = 1'b1;
    end
  end

  task automatic start(input bit we, input int n);
    @(negedge clk);
    req = 1'b1;
    req_we = we;
    req_strips = SW'(n);
  endtask

  // Edges counted from the one that samples req; ack_e is the cycle ack shows.
  task automatic wait_ack(output int ack_e, output int ncmd,
                          output bit cmd_ok, output int lastv);
    logic en, rd, vl;
    logic [SW-1:0] cs;
    mpmc11_state_t st;
    ack_e = -1; ncmd = 0; cmd_ok = 1; lastv = -1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      en = app_en; rd = app_rdy; cs = cmd_strip; vl = app_rd_data_valid;
      st = state;
      #1;
      if (en && rd) begin
        if (int'(cs) != ncmd) cmd_ok = 0;
        ncmd++;
      end
      if (vl && (st == READ_DATA0 || st == READ_DATA1)) lastv = i + 1;
      if (ack) begin ack_e = i + 1; break; end
    end
    chk("ack_seen", ack_e != -1, 1'b1);
  endtask

  task automatic close();
    repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    req = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_after_req_drop", state, IDLE);
    chk("ack_drop", ack, 1'b0);
  endtask

  initial begin
    int ae, nc, lv, n;
    bit ok, we, seen;
    #5_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int ae, nc, lv, n;
    bit ok, we, seen;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", state, IDLE);
    chk("rst_app_en", app_en, 1'b0);
    chk("rst_wren", app_wdf_wren, 1'b0);
    chk("rst_ack", ack, 1'b0);
    chk("rst_cmd_strip", cmd_strip, 0);
    @(negedge clk);
    rstn = 1'b1;

    // Calibration gate.
    req = 1'b1; req_we = 1'b1; req_strips = '0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk("calib_idle", state, IDLE);
      chk("calib_no_en", app_en, 1'b0);
    end
    @(negedge clk);
    calib_done = 1'b1;
    @(posedge clk);
    #1;
    chk("calib_preset", state, PRESET);
    wait_ack(ae, nc, ok, lv);
    close();

    // Write, 3 strips, UI always ready.
    start(1, 2);
    wait_ack(ae, nc, ok, lv);
    chk("wr_ack_cycle", ae, 8);
    chk("wr_ncmd", nc, 3);
    chk("wr_cmd_order", ok, 1'b1);
    close();

    // Read, 4 strips, 2-cycle command stall at strip 1, 10-cycle latency.
    rsp_lat = 10;
    rd_stall = 2;
    start(0, 3);
    wait_ack(ae, nc, ok, lv);
    chk("rd_ncmd", nc, 4);
    chk("rd_cmd_order", ok, 1'b1);
    chk("rd_ack_after_last_valid", ae, lv);
    close();
    rsp_lat = 2;

    // Spurious read data during a write.
    fork
      begin
        start(1, 2);
        wait_ack(ae, nc, ok, lv);
        chk("spur_wr_ack_cycle", ae, 8);
        close();
      end
      begin
        repeat (4) @(negedge clk);
        spur = 1'b1;
        @(posedge clk);
        #1;
        chk("spur_resp_strip", resp_strip, 0);
        @(negedge clk);
        spur = 1'b0;
      end
    join

    // Asynchronous reset in the middle of a write.
    start(1, 5);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (state == WRITE_DATA1) begin seen = 1; break; end
    end
    chk("reach_wd1", seen, 1'b1);
    #2;
    rstn = 1'b0;
    req = 1'b0;
    #1;
    chk("async_rst_en", app_en, 1'b0);
    chk("async_rst_state", state, IDLE);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_state", state, IDLE);
    chk("post_rst_outs", {app_en, app_wdf_wren, ack, timeout}, 4'b0);
    chk("post_rst_strips", {cmd_strip, resp_strip}, 0);

    // Write data never accepted.
    wmode = 2;
    start(1, 0);
`ifdef MPMC11_CMD_TIMEOUT_EN
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      chk("stall_no_ack", ack, 1'b0);
      if (timeout) begin
        seen = 1;
        chk("timeout_state", state, IDLE);
        break;
      end
    end
    chk("timeout_seen", seen, 1'b1);
    @(negedge clk);
    req = 1'b0;
    wmode = 0;
    repeat (3) @(posedge clk);
`else
    repeat (40) @(posedge clk);
    #1;
    chk("stall_hold_state", state, WRITE_DATA0);
    chk("stall_no_timeout", timeout, 1'b0);
    wmode = 0;
    wait_ack(ae, nc, ok, lv);
    close();
`endif

    // Randomized transactions with random readiness and read latency.
    rmode = 1;
    wmode = 1;
    for (int k = 0; k < 40; k++) begin
      we = $urandom % 2;
      n = ($urandom % 8 == 0) ? $urandom_range(8, 63) : $urandom_range(0, 7);
      rsp_lat = $urandom_range(1, 6);
      start(we, n);
      wait_ack(ae, nc, ok, lv);
      chk("rnd_ncmd", nc, n + 1);
      chk("rnd_cmd_order", ok, 1'b1);
      close();
    end

    repeat (3) @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
